// File: rtl/alu_exec_ctrl.sv
// Multicycle execute-stage sequencer: decodes a MIPS instruction onto the
// combinational ALU's inputs, captures its result and hands it downstream.
module alu_exec_ctrl #(
   parameter bit ENABLE_HAMD = 1'b1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_aluc,
   input  logic [31:0] alu_s,
   input  logic        alu_z,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [4:0]  dest,
   output logic        wreg,
   output logic        branch_taken,
   output logic        illegal
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t state, state_nxt;

   logic [5:0]  op, funct;
   logic [4:0]  rs_f, rt_f, rd_f, sa_f;
   logic [15:0] imm;
   logic        accept;

   logic [31:0] dec_a, dec_b;
   logic [3:0]  dec_aluc;
   logic [4:0]  dec_dest;
   logic        dec_legal, dec_beq, dec_bne, dec_wreg;

   logic        beq_q, bne_q;

   assign op    = instr[31:26];
   assign rs_f  = instr[25:21];
   assign rt_f  = instr[20:16];
   assign rd_f  = instr[15:11];
   assign sa_f  = instr[10:6];
   assign funct = instr[5:0];
   assign imm   = instr[15:0];

   assign accept = (state == IDLE) && in_valid;

   always_ff @(posedge clock) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = EXEC;
         EXEC:                   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // rs_f is unused by the decoder; register numbers only matter for dest
   always_comb begin
      dec_a     = rs_val;
      dec_b     = rt_val;
      dec_aluc  = 4'b0000;
      dec_dest  = rd_f;
      dec_legal = 1'b1;
      dec_beq   = 1'b0;
      dec_bne   = 1'b0;
      case (op)
         6'b000000: begin
            case (funct)
               6'b100000, 6'b100001: dec_aluc = 4'b0000;
               6'b100010, 6'b100011: dec_aluc = 4'b0100;
               6'b100100:            dec_aluc = 4'b0001;
               6'b100101:            dec_aluc = 4'b0101;
               6'b100110:            dec_aluc = 4'b0010;
               6'b101000: begin
                  if (ENABLE_HAMD) dec_aluc  = 4'b1011;
                  else             dec_legal = 1'b0;
               end
               6'b000000: begin dec_aluc = 4'b0011; dec_a = {27'b0, sa_f}; end
               6'b000010: begin dec_aluc = 4'b0111; dec_a = {27'b0, sa_f}; end
               6'b000011: begin dec_aluc = 4'b1111; dec_a = {27'b0, sa_f}; end
               default:              dec_legal = 1'b0;
            endcase
         end
         6'b001000, 6'b001001: begin dec_dest = rt_f; dec_aluc = 4'b0000; dec_b = {{16{imm[15]}}, imm}; end
         6'b001100: begin dec_dest = rt_f; dec_aluc = 4'b0001; dec_b = {16'b0, imm}; end
         6'b001101: begin dec_dest = rt_f; dec_aluc = 4'b0101; dec_b = {16'b0, imm}; end
         6'b001110: begin dec_dest = rt_f; dec_aluc = 4'b0010; dec_b = {16'b0, imm}; end
         6'b001111: begin dec_dest = rt_f; dec_aluc = 4'b0110; dec_b = {16'b0, imm}; end
         6'b000100: begin dec_dest = rt_f; dec_aluc = 4'b0100; dec_beq = 1'b1; end
         6'b000101: begin dec_dest = rt_f; dec_aluc = 4'b0100; dec_bne = 1'b1; end
         default:   dec_legal = 1'b0;
      endcase
      if (!dec_legal) begin
         dec_a    = '0;
         dec_b    = '0;
         dec_aluc = 4'b0000;
         dec_dest = '0;
         dec_beq  = 1'b0;
         dec_bne  = 1'b0;
      end
   end

   assign dec_wreg = dec_legal && !dec_beq && !dec_bne && (dec_dest != 5'd0);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         alu_a        <= '0;
         alu_b        <= '0;
         alu_aluc     <= '0;
         result       <= '0;
         dest         <= '0;
         wreg         <= 1'b0;
         branch_taken <= 1'b0;
         illegal      <= 1'b0;
         beq_q        <= 1'b0;
         bne_q        <= 1'b0;
      end else if (accept) begin
         alu_a    <= dec_a;
         alu_b    <= dec_b;
         alu_aluc <= dec_aluc;
         dest     <= dec_dest;
         wreg     <= dec_wreg;
         illegal  <= !dec_legal;
         beq_q    <= dec_beq;
         bne_q    <= dec_bne;
      end else if (state == EXEC) begin
         result       <= illegal ? '0 : alu_s;
         branch_taken <= (beq_q && alu_z) || (bne_q && !alu_z);
      end
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU closing the loop;
// a second instance with ENABLE_HAMD=0 shares the stimulus.
module tb_alu_exec_ctrl;

   logic        clock = 1'b0;
   logic        resetn, in_valid, out_ready;
   logic [31:0] instr, rs_val, rt_val;

   logic        in_ready, out_valid, wreg, branch_taken, illegal, alu_z;
   logic [31:0] alu_a, alu_b, alu_s, result;
   logic [3:0]  alu_aluc;
   logic [4:0]  dest;

   logic        in_ready2, out_valid2, wreg2, branch_taken2, illegal2, alu_z2;
   logic [31:0] alu_a2, alu_b2, alu_s2, result2;
   logic [3:0]  alu_aluc2;
   logic [4:0]  dest2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   alu_exec_ctrl #(.ENABLE_HAMD(1'b1)) dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
      .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_s(alu_s), .alu_z(alu_z),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .dest(dest),
      .wreg(wreg), .branch_taken(branch_taken), .illegal(illegal)
   );

   alu_exec_ctrl #(.ENABLE_HAMD(1'b0)) dut_nohamd (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready2),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_aluc(alu_aluc2), .alu_s(alu_s2), .alu_z(alu_z2),
      .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .dest(dest2),
      .wreg(wreg2), .branch_taken(branch_taken2), .illegal(illegal2)
   );

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
      case (c)
         4'b0000: return a + b;
         4'b0100: return a - b;
         4'b0001: return a & b;
         4'b0101: return a | b;
         4'b0010: return a ^ b;
         4'b0110: return {b[15:0], 16'h0000};
         4'b0011: return b << a[4:0];
         4'b0111: return b >> a[4:0];
         4'b1111: return 32'($signed(b) >>> a[4:0]);
         4'b1011: return 32'($countones(a ^ b));
         default: return 32'h0;
      endcase
   endfunction

   always_comb begin
      alu_s  = alu_f(alu_a, alu_b, alu_aluc);
      alu_z  = (alu_s == 32'h0);
      alu_s2 = alu_f(alu_a2, alu_b2, alu_aluc2);
      alu_z2 = (alu_s2 == 32'h0);
   end

   // Present an instruction, let it be accepted, return in the EXEC cycle.
   task automatic run_to_exec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      instr = i; rs_val = a; rt_val = b; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if ({alu_a, alu_b, alu_aluc} !== 68'h0) begin n_bad++; $display("FAIL reset_alu got %h %h %h want 0", alu_a, alu_b, alu_aluc); end
      n_cmp++; if ({result, dest, wreg, branch_taken, illegal} !== 40'h0) begin n_bad++; $display("FAIL reset_outs got %h %h %b%b%b want 0", result, dest, wreg, branch_taken, illegal); end
   endtask

   task automatic test_add();
      run_to_exec(32'h00221820, 32'd5, 32'd7);
      n_cmp++; if (alu_aluc !== 4'b0000) begin n_bad++; $display("FAIL add_aluc got %b want 0000", alu_aluc); end
      n_cmp++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin n_bad++; $display("FAIL add_ab got %h %h want 5 7", alu_a, alu_b); end
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL add_exec_hs got ov=%b ir=%b want 0 0", out_valid, in_ready); end
      @(negedge clock);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_latency got out_valid=%b want 1", out_valid); end
      n_cmp++; if (result !== 32'd12) begin n_bad++; $display("FAIL add_result got %h want 0000000c", result); end
      n_cmp++; if (dest !== 5'd3 || wreg !== 1'b1 || illegal !== 1'b0 || branch_taken !== 1'b0) begin n_bad++; $display("FAIL add_meta got d=%0d w=%b i=%b b=%b want 3 1 0 0", dest, wreg, illegal, branch_taken); end
      retire();
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL add_retire got ir=%b ov=%b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_shift();
      run_to_exec(32'h00022103, 32'd0, 32'h80000000);
      n_cmp++; if (alu_a !== 32'd4 || alu_b !== 32'h80000000 || alu_aluc !== 4'b1111) begin n_bad++; $display("FAIL sra_issue got %h %h %b want 4 80000000 1111", alu_a, alu_b, alu_aluc); end
      @(negedge clock);
      n_cmp++; if (result !== 32'hF8000000 || dest !== 5'd4 || wreg !== 1'b1) begin n_bad++; $display("FAIL sra_result got %h d=%0d w=%b want f8000000 4 1", result, dest, wreg); end
      retire();
   endtask

   task automatic test_itype();
      run_to_exec(32'h3025FFFF, 32'h12345678, 32'h0);
      n_cmp++; if (alu_b !== 32'h0000FFFF || alu_aluc !== 4'b0001) begin n_bad++; $display("FAIL andi_issue got %h %b want 0000ffff 0001", alu_b, alu_aluc); end
      @(negedge clock);
      n_cmp++; if (result !== 32'h00005678 || dest !== 5'd5 || wreg !== 1'b1) begin n_bad++; $display("FAIL andi_result got %h d=%0d w=%b want 00005678 5 1", result, dest, wreg); end
      retire();
      run_to_exec(32'h2027FFFF, 32'd10, 32'h0);
      n_cmp++; if (alu_b !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL addi_sext got %h want ffffffff", alu_b); end
      @(negedge clock);
      n_cmp++; if (result !== 32'd9 || dest !== 5'd7) begin n_bad++; $display("FAIL addi_result got %h d=%0d want 9 7", result, dest); end
      retire();
      run_to_exec(32'h3C081234, 32'h0, 32'h0);
      @(negedge clock);
      n_cmp++; if (result !== 32'h12340000 || dest !== 5'd8 || wreg !== 1'b1) begin n_bad++; $display("FAIL lui_result got %h d=%0d w=%b want 12340000 8 1", result, dest, wreg); end
      retire();
   endtask

   task automatic test_branch();
      run_to_exec(32'h10220003, 32'd9, 32'd9);
      n_cmp++; if (alu_aluc !== 4'b0100) begin n_bad++; $display("FAIL beq_aluc got %b want 0100", alu_aluc); end
      @(negedge clock);
      n_cmp++; if (branch_taken !== 1'b1 || wreg !== 1'b0) begin n_bad++; $display("FAIL beq_eq got bt=%b w=%b want 1 0", branch_taken, wreg); end
      retire();
      run_to_exec(32'h10220003, 32'd9, 32'd8);
      @(negedge clock);
      n_cmp++; if (branch_taken !== 1'b0 || wreg !== 1'b0) begin n_bad++; $display("FAIL beq_ne got bt=%b w=%b want 0 0", branch_taken, wreg); end
      retire();
      run_to_exec(32'h14220003, 32'd9, 32'd8);
      @(negedge clock);
      n_cmp++; if (branch_taken !== 1'b1 || wreg !== 1'b0) begin n_bad++; $display("FAIL bne_ne got bt=%b w=%b want 1 0", branch_taken, wreg); end
      retire();
   endtask

   task automatic test_nop();
      run_to_exec(32'h00000000, 32'd3, 32'd4);
      @(negedge clock);
      n_cmp++; if (wreg !== 1'b0 || illegal !== 1'b0 || dest !== 5'd0) begin n_bad++; $display("FAIL nop got w=%b i=%b d=%0d want 0 0 0", wreg, illegal, dest); end
      retire();
   endtask

   task automatic test_illegal();
      run_to_exec(32'hFC000000, 32'd3, 32'd4);
      n_cmp++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_aluc !== 4'b0000) begin n_bad++; $display("FAIL illegal_issue got %h %h %b want 0 0 0000", alu_a, alu_b, alu_aluc); end
      @(negedge clock);
      n_cmp++; if (out_valid !== 1'b1 || illegal !== 1'b1 || wreg !== 1'b0 || result !== 32'h0 || branch_taken !== 1'b0) begin n_bad++; $display("FAIL illegal_done got ov=%b i=%b w=%b r=%h bt=%b want 1 1 0 0 0", out_valid, illegal, wreg, result, branch_taken); end
      retire();
   endtask

   task automatic test_hamd();
      run_to_exec(32'h00223028, 32'h000000FF, 32'h0000000F);
      n_cmp++; if (alu_aluc !== 4'b1011) begin n_bad++; $display("FAIL hamd_aluc got %b want 1011", alu_aluc); end
      @(negedge clock);
      n_cmp++; if (result !== 32'd4 || dest !== 5'd6 || illegal !== 1'b0 || wreg !== 1'b1) begin n_bad++; $display("FAIL hamd_result got %h d=%0d i=%b w=%b want 4 6 0 1", result, dest, illegal, wreg); end
      n_cmp++; if (out_valid2 !== 1'b1 || illegal2 !== 1'b1 || wreg2 !== 1'b0 || result2 !== 32'h0) begin n_bad++; $display("FAIL nohamd_illegal got ov=%b i=%b w=%b r=%h want 1 1 0 0", out_valid2, illegal2, wreg2, result2); end
      retire();
   endtask

   task automatic test_backpressure();
      run_to_exec(32'h00221820, 32'd5, 32'd7);
      @(negedge clock);
      instr = 32'h3025FFFF; rs_val = 32'h12345678; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd12) begin n_bad++; $display("FAIL bp_hold%0d got ov=%b ir=%b r=%h want 1 0 0000000c", i, out_valid, in_ready, result); end
      end
      in_valid = 1'b0;
      retire();
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got ir=%b ov=%b want 1 0", in_ready, out_valid); end
      n_cmp++; if (dest !== 5'd3 || alu_aluc !== 4'b0000) begin n_bad++; $display("FAIL bp_no_accept got d=%0d aluc=%b want 3 0000", dest, alu_aluc); end
   endtask

   task automatic test_reset_exec();
      run_to_exec(32'h00221820, 32'd5, 32'd7);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin n_bad++; $display("FAIL rst_exec got ir=%b ov=%b r=%h want 1 0 0", in_ready, out_valid, result); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_exec_ov%0d got %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      run_to_exec(32'h00221822, 32'd7, 32'd5);
      @(negedge clock);
      n_cmp++; if (result !== 32'd2) begin n_bad++; $display("FAIL sub_result got %h want 2", result); end
      retire();
      run_to_exec(32'h00221825, 32'hF0, 32'h0F);
      @(negedge clock);
      n_cmp++; if (result !== 32'hFF || alu_aluc !== 4'b0101) begin n_bad++; $display("FAIL or_result got %h aluc=%b want ff 0101", result, alu_aluc); end
      retire();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr = '0; rs_val = '0; rt_val = '0;
      repeat (2) @(negedge clock);
      test_reset();
      resetn = 1'b1;
      test_add();
      test_shift();
      test_itype();
      test_branch();
      test_nop();
      test_illegal();
      test_hamd();
      test_backpressure();
      test_reset_exec();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
